// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO slice: width arithmetic and the count-update
// encoding used by the top level.
package fifo_pkg;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Count width: enough bits to hold 0..depth inclusive.
  function automatic int fcw(input int depth);
    return clog2(depth) + 1;
  endfunction

  // Pointer width: enough bits to address 0..depth-1, never below one bit.
  function automatic int fpw(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Occupancy change for one clock edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH words of DW bits, one registered write port and one
// asynchronous read port. Contents are not reset; the pointers in the top
// level decide which words are meaningful.
module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_thr.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// optional registered read port, occupancy output and sticky overflow and
// underflow flags. Works for any depth >= 2, including non-powers of two.
//
// Handshake: wr_en is the write "valid" and (!full | accepted read) is its
// "ready"; rd_en is the read "valid" and !empty is its "ready". A transfer
// happens at a rising clk edge where valid and ready are both high and
// clk_en & en are high. A valid that meets no ready is refused and latches
// the matching sticky error flag; requests are never queued.
module sync_fifo_thr
  import fifo_pkg::*;
#(
  parameter int FD     = 16,
  parameter int DW     = 32,
  parameter int AF_LVL = FD - 2,
  parameter int AE_LVL = 2,
  parameter int OREG   = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               en,
  input  logic [DW-1:0]      in,
  input  logic               wr_en,
  input  logic               rd_en,
  output logic [DW-1:0]      out,
  output logic [clog2(FD):0] cnt,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               half,
  output logic               ovf,
  output logic               udf
);

  localparam int FCW = fcw(FD);
  localparam int FPW = fpw(FD);

  localparam logic [FPW-1:0] PTR_LAST = FPW'(FD - 1);
  localparam logic [FCW-1:0] CNT_FULL = FCW'(FD);
  localparam logic [FCW-1:0] CNT_AF   = FCW'(AF_LVL);
  localparam logic [FCW-1:0] CNT_AE   = FCW'(AE_LVL);
  localparam logic [FCW-1:0] CNT_HALF = FCW'(FD / 2);

  logic [FPW-1:0] wp;
  logic [FPW-1:0] rp;
  logic [FCW-1:0] cnt_q;
  logic           ovf_q;
  logic           udf_q;
  logic           active;
  logic           wr_ok;
  logic           rd_ok;
  cnt_op_e        cnt_op;
  logic [DW-1:0]  mem_rdata;

  // Pointer advance with an explicit wrap so any depth works.
  function automatic logic [FPW-1:0] ptr_next(input logic [FPW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + FPW'(1);
  endfunction

  // A read is judged first: at the full boundary it frees the slot that the
  // simultaneous write then uses. At the empty boundary the read is refused
  // while the write still lands.
  assign active = clk_en & en;
  assign rd_ok  = active & rd_en & ~empty;
  assign wr_ok  = active & wr_en & (~full | rd_ok);

  // Decide how the occupancy moves this edge.
  always_comb begin
    cnt_op = CNT_HOLD;
    if (wr_ok && !rd_ok) begin
      cnt_op = CNT_INC;
    end else if (rd_ok && !wr_ok) begin
      cnt_op = CNT_DEC;
    end
  end

  // Write and read pointers; a flush (en low) rewinds both regardless of clk_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (!en) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_ok) begin
        wp <= ptr_next(wp);
      end
      if (rd_ok) begin
        rp <= ptr_next(rp);
      end
    end
  end

  // Occupancy count, the single source for every status flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else begin
      case (cnt_op)
        CNT_INC: cnt_q <= cnt_q + FCW'(1);
        CNT_DEC: cnt_q <= cnt_q - FCW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error flags: set on a refused request, cleared by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (!en) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (active && wr_en && !wr_ok) begin
        ovf_q <= 1'b1;
      end
      if (active && rd_en && !rd_ok) begin
        udf_q <= 1'b1;
      end
    end
  end

  // Status flags decode only the registered count, so they move only at edges.
  assign cnt          = cnt_q;
  assign full         = (cnt_q == CNT_FULL);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= CNT_AF);
  assign almost_empty = (cnt_q <= CNT_AE);
  assign half         = (cnt_q <= CNT_HALF);
  assign ovf          = ovf_q;
  assign udf          = udf_q;

  fifo_mem #(
    .DEPTH (FD),
    .DW    (DW),
    .AW    (FPW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wp),
    .wdata (in),
    .raddr (rp),
    .rdata (mem_rdata)
  );

  if (OREG != 0) begin : g_out_reg
    logic [DW-1:0] out_q;

    // Registered read port: capture the head word as it is popped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else if (!en) begin
        out_q <= '0;
      end else if (rd_ok) begin
        out_q <= mem_rdata;
      end
    end

    assign out = out_q;
  end else begin : g_out_show
    // Show-ahead read port: the head word is always presented.
    assign out = mem_rdata;
  end

endmodule

// File: tb/tb_sync_fifo_thr.sv
// Directed bench for sync_fifo_thr. Two FD=16 instances (show-ahead and
// registered read port) share one stimulus stream; an FD=5 instance checks
// pointer wrap at a non-power-of-two depth against an expected-data queue.
module tb_sync_fifo_thr;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clk_en;
  logic        en;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] din;

  logic [31:0] out_a, out_b;
  logic [4:0]  cnt_a, cnt_b;
  logic        full_a, empty_a, af_a, ae_a, half_a, ovf_a, udf_a;
  logic        full_b, empty_b, af_b, ae_b, half_b, ovf_b, udf_b;

  logic        en5, wr5, rd5;
  logic [31:0] din5, out5;
  logic [3:0]  cnt5;
  logic        full5, empty5, af5, ae5, half5, ovf5, udf5;

  sync_fifo_thr #(.FD(16), .DW(32), .AF_LVL(14), .AE_LVL(2), .OREG(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .en(en), .in(din),
    .wr_en(wr_en), .rd_en(rd_en), .out(out_a), .cnt(cnt_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
    .half(half_a), .ovf(ovf_a), .udf(udf_a)
  );

  sync_fifo_thr #(.FD(16), .DW(32), .AF_LVL(14), .AE_LVL(2), .OREG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .en(en), .in(din),
    .wr_en(wr_en), .rd_en(rd_en), .out(out_b), .cnt(cnt_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
    .half(half_b), .ovf(ovf_b), .udf(udf_b)
  );

  sync_fifo_thr #(.FD(5), .DW(32), .OREG(0)) u_dut_5 (
    .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .en(en5), .in(din5),
    .wr_en(wr5), .rd_en(rd5), .out(out5), .cnt(cnt5),
    .full(full5), .empty(empty5), .almost_full(af5), .almost_empty(ae5),
    .half(half5), .ovf(ovf5), .udf(udf5)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Status of both FD=16 instances for an expected occupancy c.
  task automatic check_state(input string tag, input int c);
    check({tag, "_cnt_a"},   32'(cnt_a),   32'(c));
    check({tag, "_cnt_b"},   32'(cnt_b),   32'(c));
    check({tag, "_empty"},   32'(empty_a), 32'(c == 0));
    check({tag, "_full"},    32'(full_a),  32'(c == 16));
    check({tag, "_afull"},   32'(af_a),    32'(c >= 14));
    check({tag, "_aempty"},  32'(ae_a),    32'(c <= 2));
    check({tag, "_half"},    32'(half_a),  32'(c <= 8));
    check({tag, "_full_b"},  32'(full_b),  32'(c == 16));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [31:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
  endtask

  task automatic fill(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, base + 32'(i));
      tick();
    end
    drive(1'b0, 1'b0, 32'd0);
  endtask

  int wr_tab[12] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1};
  int rd_tab[12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};

  // ---------------- stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    clk_en = 1'b1;
    en     = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    en5  = 1'b1;
    wr5  = 1'b0;
    rd5  = 1'b0;
    din5 = 32'd0;

    #12;
    check_state("reset", 0);
    check("reset_ovf", 32'(ovf_a), 32'd0);
    check("reset_udf", 32'(udf_a), 32'd0);
    check("reset_out_b", out_b, 32'd0);
    check("reset_empty5", 32'(empty5), 32'd1);
    rst_n = 1'b1;
    tick();

    // Fill 16 words 0..15, watching every threshold.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 32'(i));
      tick();
      check_state("fill", i + 1);
    end
    check("fill_head_a", out_a, 32'd0);
    check("fill_ovf_pre", 32'(ovf_a), 32'd0);

    // 17th write is refused.
    drive(1'b1, 1'b0, 32'd99);
    tick();
    check_state("overfill", 16);
    check("overfill_ovf_a", 32'(ovf_a), 32'd1);
    check("overfill_ovf_b", 32'(ovf_b), 32'd1);
    check("overfill_udf", 32'(udf_a), 32'd0);

    // Drain 16 words in order; registered port lags by one edge.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      check("drain_out_a", out_a, 32'(i));
      tick();
      check("drain_out_b", out_b, 32'(i));
      check_state("drain", 15 - i);
    end

    // 17th read is refused.
    drive(1'b0, 1'b1, 32'd0);
    tick();
    check_state("underrun", 0);
    check("underrun_udf_a", 32'(udf_a), 32'd1);
    check("underrun_udf_b", 32'(udf_b), 32'd1);
    check("underrun_out_b_hold", out_b, 32'd15);

    // Flush clears the sticky flags and the output register.
    drive(1'b0, 1'b0, 32'd0);
    en = 1'b0;
    tick();
    en = 1'b1;
    check_state("flush1", 0);
    check("flush1_ovf", 32'(ovf_a), 32'd0);
    check("flush1_udf", 32'(udf_a), 32'd0);
    check("flush1_out_b", out_b, 32'd0);

    // Simultaneous read and write while full.
    fill(32'd100, 16);
    check_state("refill", 16);
    drive(1'b1, 1'b1, 32'd200);
    check("fullrw_head_pre", out_a, 32'd100);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    check_state("fullrw", 16);
    check("fullrw_ovf", 32'(ovf_a), 32'd0);
    check("fullrw_out_b", out_b, 32'd100);
    check("fullrw_head_post", out_a, 32'd101);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      check("fullrw_drain_a", out_a, (i < 15) ? 32'(101 + i) : 32'd200);
      tick();
      check("fullrw_drain_b", out_b, (i < 15) ? 32'(101 + i) : 32'd200);
    end
    check_state("fullrw_empty", 0);

    // Simultaneous read and write while empty: only the write lands.
    drive(1'b1, 1'b1, 32'd300);
    tick();
    check_state("emptyrw", 1);
    check("emptyrw_udf", 32'(udf_a), 32'd1);
    check("emptyrw_out_a", out_a, 32'd300);
    check("emptyrw_out_b_hold", out_b, 32'd200);
    drive(1'b0, 1'b1, 32'd0);
    tick();
    check("emptyrw_pop_b", out_b, 32'd300);
    check_state("emptyrw_pop", 0);

    // Flush with cnt=7 and ovf=1, clk_en low at the same time.
    fill(32'd600, 16);
    drive(1'b1, 1'b0, 32'd700);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      tick();
    end
    check_state("preflush", 7);
    check("preflush_ovf", 32'(ovf_a), 32'd1);
    clk_en = 1'b0;
    en     = 1'b0;
    drive(1'b1, 1'b1, 32'd0);
    tick();
    clk_en = 1'b1;
    en     = 1'b1;
    drive(1'b0, 1'b0, 32'd0);
    check_state("flush2", 0);
    check("flush2_ovf", 32'(ovf_a), 32'd0);
    check("flush2_udf", 32'(udf_a), 32'd0);
    check("flush2_out_b", out_b, 32'd0);

    // clk_en gating: requests ignored, nothing moves.
    fill(32'd400, 3);
    check_state("gate_pre", 3);
    clk_en = 1'b0;
    drive(1'b1, 1'b1, 32'd777);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_state("gate", 3);
      check("gate_ovf", 32'(ovf_a), 32'd0);
      check("gate_udf", 32'(udf_a), 32'd0);
      check("gate_out_b", out_b, 32'd0);
    end
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'd0);
      check("gate_drain_a", out_a, 32'(400 + i));
      tick();
      check("gate_drain_b", out_b, 32'(400 + i));
    end
    drive(1'b0, 1'b0, 32'd0);
    check_state("gate_post", 0);

    // Asynchronous reset between edges mid-stream.
    fill(32'd500, 3);
    drive(1'b0, 1'b1, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'd0);
    check("arst_pre_out_b", out_b, 32'd500);
    check_state("arst_pre", 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("arst", 0);
    check("arst_out_b", out_b, 32'd0);
    check("arst_ovf", 32'(ovf_a), 32'd0);
    check("arst_udf", 32'(udf_a), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check_state("arst_post", 0);

    // FD=5: twelve mixed cycles exercising both pointer wraps.
    for (int i = 0; i < 12; i++) begin
      logic rd_acc;
      logic wr_acc;
      wr5  = (wr_tab[i] != 0);
      rd5  = (rd_tab[i] != 0);
      din5 = 32'(10 + i);
      rd_acc = rd5 && (exp_q.size() > 0);
      wr_acc = wr5 && ((exp_q.size() < 5) || rd_acc);
      if (exp_q.size() > 0) begin
        check("d5_head", out5, exp_q[0]);
      end
      tick();
      if (rd_acc) begin
        void'(exp_q.pop_front());
      end
      if (wr_acc) begin
        exp_q.push_back(din5);
      end
      check("d5_cnt", 32'(cnt5), 32'(exp_q.size()));
      check("d5_full", 32'(full5), 32'(exp_q.size() == 5));
    end
    wr5 = 1'b0;
    while (exp_q.size() > 0) begin
      rd5 = 1'b1;
      check("d5_drain", out5, exp_q[0]);
      tick();
      void'(exp_q.pop_front());
    end
    rd5 = 1'b0;
    check("d5_empty", 32'(empty5), 32'd1);
    check("d5_ovf", 32'(ovf5), 32'd0);
    check("d5_udf", 32'(udf5), 32'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_thr.md
# sync_fifo_thr

Parametrised single-clock FIFO with programmable almost-full and almost-empty thresholds, an optional registered read port, an occupancy count output and sticky overflow/underflow error flags. It is the general-purpose buffer between pipeline stages in the datapath, for example between the iteration engine and the pixel writer. It supports any depth ≥ 2, not only powers of two, and handles a simultaneous read and write at the full and empty boundaries.

## Interface
Parameters:
- `FD`, 16: depth in words, ≥ 2, any integer.
- `DW`, 32: data width.
- `AF_LVL`, FD-2: `almost_full` asserts when count ≥ AF_LVL; range 1..FD.
- `AE_LVL`, 2: `almost_empty` asserts when count ≤ AE_LVL; range 0..FD-1.
- `OREG`, 0: 0 = show-ahead combinational read data; 1 = registered read data.

Ports:
- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `clk_en` in 1: clock enable. When low, all state holds, except during a flush.
- `en` in 1: FIFO enable. When low, the FIFO is flushed synchronously.
- `in` in DW: write data.
- `wr_en` in 1: write request.
- `rd_en` in 1: read request.
- `out` out DW: read data.
- `cnt` out clog2(FD)+1: occupancy, 0..FD.
- `full`, `empty`, `almost_full`, `almost_empty`, `half` out 1 each: status flags. `half` means count ≤ FD/2.
- `ovf`, `udf` out 1 each: sticky flags for a refused write or a refused read.

## Operation
- Accepted write: `wr_ok` = clk_en & en & wr_en & (!full | rd_ok).
- Accepted read: `rd_ok` = clk_en & en & rd_en & !empty.
- On `wr_ok`: the word is written to mem[wp], and wp advances. wp wraps from FD-1 to 0 by explicit compare, not by natural overflow.
- On `rd_ok`: rp advances, with the same wrap rule.
- Count update:
  - +1 on `wr_ok` & !`rd_ok`.
  - −1 on `rd_ok` & !`wr_ok`.
  - Unchanged when both or neither occur.
- Full boundary: with the FIFO full and both requests present, both are accepted. The read returns the oldest word and the write fills the freed slot. Count stays at FD and `ovf` is not set.
- Empty boundary: with the FIFO empty and both requests present, only the write is accepted. Count becomes 1 and `udf` is set.
- `ovf` sets on clk_en & en & wr_en & !`wr_ok`.
- `udf` sets on clk_en & en & rd_en & !`rd_ok`.
- Both error flags are sticky until reset or a flush.
- Flags are decoded from the registered count only, so they are glitch-free:
  - `full` = (cnt==FD).
  - `empty` = (cnt==0).
  - `almost_full` = (cnt≥AF_LVL).
  - `almost_empty` = (cnt≤AE_LVL).
- Read data with OREG=0: `out` = mem[rp] combinationally. It is valid while !empty and undefined-but-stable while empty.
- Read data with OREG=1: `out` loads mem[rp] on `rd_ok` and holds otherwise.
- Flush (en=0 at a clk edge, independent of clk_en):
  - wp, rp and cnt are cleared to 0.
  - `ovf` and `udf` are cleared.
  - `out` is cleared to 0 when OREG=1.
  - No requests are accepted that cycle.
  - Memory contents are not cleared.

## Timing
- Reset values: cnt=0, empty=1, full=0, almost_empty=1, almost_full=0, half=1, ovf=0, udf=0, out=0 (OREG=1).
- Write-to-visible latency: a word written at edge N updates `cnt`/`empty` after edge N.
  - OREG=0: `out` shows the word in cycle N+1.
  - OREG=1: the word appears on `out` one cycle after the `rd_ok` edge that pops it.
- Status flags change only on clk edges, one cycle after the request that caused the change.
- Reset asserted mid-operation clears all state immediately, with no clock needed. The FIFO is logically empty from then on.
- clk_en low with en high: all state holds, and requests are ignored without setting error flags.

## Structure
- Shared package `fifo_pkg`:
  - `clog2` function.
  - Width helpers FCW = clog2(FD)+1 and FPW = clog2(FD).
- Sub-module `fifo_mem`: DW×FD storage with one write port (registered) and one asynchronous read port.
- Top level holds the pointers, count, flags and OREG output register, selected by a generate on OREG.

## Test plan
- Fill, FD=16, AF_LVL=14: write 16 words with no reads. Required response:
  - cnt 0→16.
  - almost_full rises when cnt=14.
  - full rises after the 16th edge.
  - A 17th write sets ovf and leaves cnt=16.
- Drain, OREG=0 then OREG=1: after the fill, read 16 words. Required response:
  - Data are returned in write order, with out values 0..15.
  - With OREG=1 each word lags by one cycle.
  - A 17th read sets udf, and empty stays 1.
- Non-power-of-two depth, FD=5: run 12 write/read cycles. Required response:
  - Pointers wrap 4→0.
  - Data order is preserved with no corruption.
  - cnt never exceeds 5.
- Simultaneous requests:
  - When full: cnt stays FD, the oldest word is read, the new word is stored, and ovf=0.
  - When empty: cnt=1, udf=1, and the word is readable next cycle.
- Flush and reset:
  - en=0 for one cycle with cnt=7 and ovf=1: cnt=0, empty=1, ovf=0.
  - rst_n pulsed low between edges mid-stream: outputs go to their reset values asynchronously.
- clk_en gating: clk_en=0 with wr_en=rd_en=1 for 4 cycles leaves cnt, the pointers and the error flags unchanged.
